// File: rtl/vid_frmbuf_ctrl_slave.sv
// vid_frmbuf_ctrl_slave: AXI4-Lite control/config slave for the video
// frame-buffer fetch core. Holds user geometry/format/plane registers and
// copies them to the shadowed cfg_* outputs when the core accepts a start.
// Ports: clk, reset (sync, active-high); AXI4-Lite s_aw*/s_w*/s_b*/s_ar*/s_r*;
//   core handshake ap_start (out), ap_ready/ap_done/ap_idle (in);
//   cfg_width/cfg_height/cfg_stride/cfg_format/cfg_plane1 (out); irq (out).
// Option: define VFB_IRQ_EN to add GIE/IER/ISR at 0x04/0x08/0x0C and drive irq.
module vid_frmbuf_ctrl_slave #(
   parameter int ADDR_W = 6,
   parameter int DIM_W  = 16,
   parameter int FMT_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_awaddr,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [ADDR_W-1:0] s_araddr,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic              ap_start,
   input  logic              ap_ready,
   input  logic              ap_done,
   input  logic              ap_idle,
   output logic [DIM_W-1:0]  cfg_width,
   output logic [DIM_W-1:0]  cfg_height,
   output logic [DIM_W-1:0]  cfg_stride,
   output logic [FMT_W-1:0]  cfg_format,
   output logic [31:0]       cfg_plane1,
   output logic              irq
);
   localparam int WA_W = ADDR_W - 2;
   localparam logic [WA_W-1:0] A_CTRL   = WA_W'(0);
   localparam logic [WA_W-1:0] A_WIDTH  = WA_W'(4);
   localparam logic [WA_W-1:0] A_HEIGHT = WA_W'(6);
   localparam logic [WA_W-1:0] A_STRIDE = WA_W'(8);
   localparam logic [WA_W-1:0] A_FORMAT = WA_W'(10);
   localparam logic [WA_W-1:0] A_PLANE1 = WA_W'(12);
`ifdef VFB_IRQ_EN
   localparam logic [WA_W-1:0] A_GIE    = WA_W'(1);
   localparam logic [WA_W-1:0] A_IER    = WA_W'(2);
   localparam logic [WA_W-1:0] A_ISR    = WA_W'(3);
   logic       gie;
   logic [1:0] ier;
   logic [1:0] isr;
   logic       irq_q;
`endif
   localparam logic [1:0] RESP_OK  = 2'b00;
   localparam logic [1:0] RESP_ERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;
   wstate_t wstate, wstate_nx;
   rstate_t rstate, rstate_nx;

   logic            aw_got, w_got;
   logic [WA_W-1:0] aw_word;
   logic [31:0]     w_data;
   logic [3:0]      w_strb;
   logic            aw_hs, w_hs, ar_hs, wr_fire, wr_ok;
   logic [WA_W-1:0] wa, ra;
   logic [31:0]     wd, rd_val;
   logic [3:0]      ws;
   logic            ap_start_q, auto_restart, done_q;
   logic [DIM_W-1:0] width_r, height_r, stride_r;
   logic [FMT_W-1:0] format_r;
   logic [31:0]      plane1_r;
   logic             unused_ok;

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0]  s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
      return r;
   endfunction

   function automatic logic mapped(input logic [WA_W-1:0] a);
      logic m;
      case (a)
         A_CTRL, A_WIDTH, A_HEIGHT,
         A_STRIDE, A_FORMAT, A_PLANE1: m = 1'b1;
`ifdef VFB_IRQ_EN
         A_GIE, A_IER, A_ISR:         m = 1'b1;
`endif
         default:                      m = 1'b0;
      endcase
      return m;
   endfunction

   // address LSBs select bytes within a word and are not decoded
   assign unused_ok = ^{s_awaddr[1:0], s_araddr[1:0]};

   assign aw_hs = s_awvalid && s_awready;
   assign w_hs  = s_wvalid && s_wready;
   assign ar_hs = s_arvalid && s_arready;

   // a beat captured earlier takes precedence over the live bus
   assign wa = aw_got ? aw_word : s_awaddr[ADDR_W-1:2];
   assign wd = w_got ? w_data : s_wdata;
   assign ws = w_got ? w_strb : s_wstrb;
   assign wr_fire = (wstate == W_IDLE) &&
                    (aw_got || aw_hs) && (w_got || w_hs);
   assign wr_ok = mapped(wa);
   assign ra = s_araddr[ADDR_W-1:2];

   // ---- write FSM ----
   always_ff @(posedge clk) begin
      if (reset) wstate <= W_IDLE;
      else       wstate <= wstate_nx;
   end

   always_comb begin
      wstate_nx = wstate;
      case (wstate)
         W_IDLE:  if (wr_fire)  wstate_nx = W_RESP;
         W_RESP:  if (s_bready) wstate_nx = W_IDLE;
         default:               wstate_nx = W_IDLE;
      endcase
   end

   always_comb begin
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      if (!reset) begin
         case (wstate)
            W_IDLE: begin
               s_awready = !aw_got;
               s_wready  = !w_got;
            end
            W_RESP:  s_bvalid = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
         aw_word <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         s_bresp <= RESP_OK;
      end else if (wr_fire) begin
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
         s_bresp <= wr_ok ? RESP_OK : RESP_ERR;
      end else begin
         if (aw_hs) begin
            aw_got  <= 1'b1;
            aw_word <= s_awaddr[ADDR_W-1:2];
         end
         if (w_hs) begin
            w_got  <= 1'b1;
            w_data <= s_wdata;
            w_strb <= s_wstrb;
         end
      end
   end

   // ---- read FSM ----
   always_ff @(posedge clk) begin
      if (reset) rstate <= R_IDLE;
      else       rstate <= rstate_nx;
   end

   always_comb begin
      rstate_nx = rstate;
      case (rstate)
         R_IDLE:  if (ar_hs)    rstate_nx = R_DATA;
         R_DATA:  if (s_rready) rstate_nx = R_IDLE;
         default:               rstate_nx = R_IDLE;
      endcase
   end

   always_comb begin
      s_arready = !reset && (rstate == R_IDLE);
      s_rvalid  = !reset && (rstate == R_DATA);
   end

   always_comb begin
      rd_val = '0;
      case (ra)
         A_CTRL:   rd_val = {24'b0, auto_restart, 4'b0,
                             ap_idle, done_q, ap_start_q};
         A_WIDTH:  rd_val = 32'(width_r);
         A_HEIGHT: rd_val = 32'(height_r);
         A_STRIDE: rd_val = 32'(stride_r);
         A_FORMAT: rd_val = 32'(format_r);
         A_PLANE1: rd_val = plane1_r;
`ifdef VFB_IRQ_EN
         A_GIE:    rd_val = {31'b0, gie};
         A_IER:    rd_val = {30'b0, ier};
         A_ISR:    rd_val = {30'b0, isr};
`endif
         default:  rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_rdata <= '0;
         s_rresp <= RESP_OK;
      end else if (ar_hs) begin
         s_rdata <= rd_val;
         s_rresp <= mapped(ra) ? RESP_OK : RESP_ERR;
      end
   end

   // ---- registers, start/done handshake, config shadow ----
   always_ff @(posedge clk) begin
      if (reset) begin
         ap_start_q   <= 1'b0;
         auto_restart <= 1'b0;
         done_q       <= 1'b0;
         width_r      <= '0;
         height_r     <= '0;
         stride_r     <= '0;
         format_r     <= '0;
         plane1_r     <= '0;
         cfg_width    <= '0;
         cfg_height   <= '0;
         cfg_stride   <= '0;
         cfg_format   <= '0;
         cfg_plane1   <= '0;
      end else begin
         if (ap_start_q && ap_ready) begin
            cfg_width  <= width_r;
            cfg_height <= height_r;
            cfg_stride <= stride_r;
            cfg_format <= format_r;
            cfg_plane1 <= plane1_r;
            if (!auto_restart) ap_start_q <= 1'b0;
         end
         // a done event beats the clear-on-read of the same cycle
         if (ap_done)
            done_q <= 1'b1;
         else if (ar_hs && ra == A_CTRL)
            done_q <= 1'b0;
         if (wr_fire && wr_ok) begin
            case (wa)
               A_CTRL: if (ws[0]) begin
                  if (wd[0]) ap_start_q <= 1'b1;
                  auto_restart <= wd[7];
               end
               A_WIDTH:  width_r  <= DIM_W'(merge(32'(width_r), wd, ws));
               A_HEIGHT: height_r <= DIM_W'(merge(32'(height_r), wd, ws));
               A_STRIDE: stride_r <= DIM_W'(merge(32'(stride_r), wd, ws));
               A_FORMAT: format_r <= FMT_W'(merge(32'(format_r), wd, ws));
               A_PLANE1: plane1_r <= merge(plane1_r, wd, ws);
               default: ;
            endcase
         end
      end
   end

   assign ap_start = ap_start_q;

`ifdef VFB_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         gie   <= 1'b0;
         ier   <= 2'b00;
         isr   <= 2'b00;
         irq_q <= 1'b0;
      end else begin
         if (wr_fire && wa == A_GIE && ws[0]) gie <= wd[0];
         if (wr_fire && wa == A_IER && ws[0]) ier <= wd[1:0];
         isr <= (isr ^ ((wr_fire && wa == A_ISR && ws[0]) ?
                        wd[1:0] : 2'b00))
              | {ap_start_q & ap_ready, ap_done};
         irq_q <= gie & |(ier & isr);
      end
   end
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vid_frmbuf_ctrl_slave.sv
// tb_vid_frmbuf_ctrl_slave: directed + randomized bench for the frame-buffer
// control slave, checked against a register-map reference model.
module tb_vid_frmbuf_ctrl_slave;
   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  s_awaddr, s_araddr;
   logic        s_awvalid, s_awready, s_wvalid, s_wready;
   logic [31:0] s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  s_bresp, s_rresp;
   logic        s_bvalid, s_bready, s_arvalid, s_arready;
   logic        s_rvalid, s_rready;
   logic        ap_start, ap_ready, ap_done, ap_idle, irq;
   logic [15:0] cfg_width, cfg_height, cfg_stride;
   logic [5:0]  cfg_format;
   logic [31:0] cfg_plane1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vid_frmbuf_ctrl_slave dut (
      .clk(clk), .reset(reset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
      .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
      .s_bready(s_bready), .s_araddr(s_araddr), .s_arvalid(s_arvalid),
      .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .ap_start(ap_start),
      .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_stride(cfg_stride), .cfg_format(cfg_format),
      .cfg_plane1(cfg_plane1), .irq(irq)
   );

   // ---------------- reference model ----------------
   logic [31:0] m_reg [0:63];
   bit          m_start, m_ar, m_done;
   bit [1:0]    m_isr;
   logic [31:0] m_cw, m_ch, m_cs, m_cf, m_cp;

   task automatic m_reset();
      for (int i = 0; i < 64; i++) m_reg[i] = '0;
      m_start = 0; m_ar = 0; m_done = 0; m_isr = 0;
      m_cw = 0; m_ch = 0; m_cs = 0; m_cf = 0; m_cp = 0;
   endtask

   function automatic bit m_mapped(int off);
      bit m;
      m = (off == 'h00) || (off == 'h10) || (off == 'h18) ||
          (off == 'h20) || (off == 'h28) || (off == 'h30);
`ifdef VFB_IRQ_EN
      m = m || (off >= 'h04 && off <= 'h0C);
`endif
      return m;
   endfunction

   function automatic logic [31:0] f_mask(int off);
      case (off)
         'h10, 'h18, 'h20: return 32'h0000_FFFF;
         'h28:             return 32'h0000_003F;
         'h30:             return 32'hFFFF_FFFF;
         'h04:             return 32'h1;
         'h08:             return 32'h3;
         default:          return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] bmerge(logic [31:0] o, logic [31:0] d,
                                          logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_ctrl();
      return (32'(m_ar) << 7) | (32'(ap_idle) << 2) |
             (32'(m_done) << 1) | 32'(m_start);
   endfunction

   task automatic m_write(input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
      int off;
      off = int'(a) & 'h3C;
      resp = 2'b10;
      if (!m_mapped(off)) return;
      resp = 2'b00;
      if (off == 0) begin
         if (s[0]) begin
            if (d[0]) m_start = 1;
            m_ar = d[7];
         end
      end
`ifdef VFB_IRQ_EN
      else if (off == 'h0C) begin
         if (s[0]) m_isr ^= d[1:0];
      end
`endif
      else m_reg[off] = bmerge(m_reg[off], d, s) & f_mask(off);
   endtask

   task automatic m_read(input logic [5:0] a, input bit pulse,
                         output logic [31:0] v, output logic [1:0] resp);
      int off;
      off = int'(a) & 'h3C;
      v = 0;
      resp = 2'b10;
      if (m_mapped(off)) begin
         resp = 2'b00;
         if (off == 0) v = m_ctrl();
`ifdef VFB_IRQ_EN
         else if (off == 'h0C) v = 32'(m_isr);
`endif
         else v = m_reg[off];
      end
      if (pulse) begin
         m_done = 1;
         m_isr[0] = 1;
      end else if (off == 0) m_done = 0;
   endtask

   task automatic m_ready_pulse();
      if (m_start) begin
         m_cw = m_reg['h10]; m_ch = m_reg['h18]; m_cs = m_reg['h20];
         m_cf = m_reg['h28]; m_cp = m_reg['h30];
         m_isr[1] = 1;
         if (!m_ar) m_start = 0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_ap_start"}, ap_start, m_start);
      chk({tag, "_cfg_w"}, cfg_width, m_cw);
      chk({tag, "_cfg_h"}, cfg_height, m_ch);
      chk({tag, "_cfg_s"}, cfg_stride, m_cs);
      chk({tag, "_cfg_f"}, cfg_format, m_cf);
      chk({tag, "_cfg_p"}, cfg_plane1, m_cp);
`ifndef VFB_IRQ_EN
      chk({tag, "_irq0"}, irq, 0);
`endif
   endtask

   // ---------------- bus tasks (enter/leave 1 after posedge) ----------
   task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int aw_dly,
                            input int w_dly, input int b_stall);
      bit aw_ok, w_ok;
      int cyc;
      logic [1:0] exp, resp;
      aw_ok = 0; w_ok = 0; cyc = 0;
      s_awaddr = a; s_wdata = d; s_wstrb = s;
      while (!(aw_ok && w_ok) && cyc < 50) begin
         s_awvalid = !aw_ok && cyc >= aw_dly;
         s_wvalid  = !w_ok && cyc >= w_dly;
         @(negedge clk);
         chk("bvalid_early", s_bvalid, 0);
         if (aw_ok) chk("awready_held_low", s_awready, 0);
         if (w_ok) chk("wready_held_low", s_wready, 0);
         if (s_awvalid && s_awready) aw_ok = 1;
         if (s_wvalid && s_wready) w_ok = 1;
         @(posedge clk); #1;
         cyc++;
      end
      s_awvalid = 0; s_wvalid = 0;
      chk("aw_w_accept", 32'(aw_ok && w_ok), 1);
      m_write(a, d, s, exp);
      @(negedge clk);
      chk("bvalid_latency", s_bvalid, 1);
      chk("bresp", s_bresp, exp);
      resp = s_bresp;
      for (int i = 0; i < b_stall; i++) begin
         @(posedge clk); @(negedge clk);
         chk("bvalid_hold", s_bvalid, 1);
         chk("bresp_hold", s_bresp, resp);
      end
      s_bready = 1;
      @(posedge clk); #1;
      s_bready = 0;
      @(negedge clk);
      chk("bvalid_single", s_bvalid, 0);
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [5:0] a, input int r_stall,
                           input bit done_pulse, output logic [31:0] v);
      bit hs;
      int cyc;
      logic [31:0] ev;
      logic [1:0] er;
      hs = 0; cyc = 0;
      s_araddr = a; s_arvalid = 1; ap_done = done_pulse;
      while (!hs && cyc < 50) begin
         @(negedge clk);
         hs = s_arready;
         @(posedge clk); #1;
         ap_done = 0;
         cyc++;
      end
      s_arvalid = 0;
      chk("ar_accept", 32'(hs), 1);
      m_read(a, done_pulse, ev, er);
      @(negedge clk);
      chk("rvalid_latency", s_rvalid, 1);
      chk("rdata", s_rdata, ev);
      chk("rresp", s_rresp, er);
      v = s_rdata;
      for (int i = 0; i < r_stall; i++) begin
         @(posedge clk); @(negedge clk);
         chk("rvalid_hold", s_rvalid, 1);
         chk("rdata_hold", s_rdata, v);
      end
      s_rready = 1;
      @(posedge clk); #1;
      s_rready = 0;
      @(negedge clk);
      chk("rvalid_single", s_rvalid, 0);
      @(posedge clk); #1;
   endtask

   task automatic pulse_ready();
      ap_ready = 1;
      @(posedge clk); #1;
      ap_ready = 0;
      m_ready_pulse();
      check_state("ready");
   endtask

   task automatic pulse_done();
      ap_done = 1;
      @(posedge clk); #1;
      ap_done = 0;
      m_done = 1;
      m_isr[0] = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [5:0] offs [12] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h18,
                             6'h20, 6'h28, 6'h30, 6'h14, 6'h3C, 6'h38};

   initial begin
      logic [31:0] rd;
      int op;
      logic [5:0] a;
      reset = 1; ap_ready = 0; ap_done = 0; ap_idle = 1;
      s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0;
      s_bready = 0; s_araddr = 0; s_arvalid = 0; s_rready = 0;
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", s_awready, 0);
      chk("rst_wready", s_wready, 0);
      chk("rst_arready", s_arready, 0);
      chk("rst_bvalid", s_bvalid, 0);
      chk("rst_rvalid", s_rvalid, 0);
      chk("rst_bresp", s_bresp, 0);
      chk("rst_rresp", s_rresp, 0);
      chk("rst_rdata", s_rdata, 0);
      chk("rst_irq", irq, 0);
      check_state("rst");
      @(posedge clk); #1;
      reset = 0;

      // basic geometry write/readback; shadow untouched
      axi_read(6'h10, 0, 0, rd);
      axi_read(6'h18, 0, 0, rd);
      axi_read(6'h30, 0, 0, rd);
      axi_write(6'h10, 640, 4'hF, 0, 0, 0);
      axi_write(6'h18, 480, 4'hF, 0, 0, 0);
      axi_write(6'h30, 32'h0010_0000, 4'hF, 0, 0, 0);
      axi_write(6'h28, 20, 4'hF, 0, 0, 0);
      axi_read(6'h10, 0, 0, rd);
      chk("width_640", rd, 640);
      axi_read(6'h18, 0, 0, rd);
      axi_read(6'h30, 0, 0, rd);
      axi_read(6'h28, 0, 0, rd);
      check_state("prestart");
      chk("cfg_w_still0", cfg_width, 0);

      // start with auto_restart, then without
      axi_write(6'h00, 32'h81, 4'hF, 0, 0, 0);
      pulse_ready();
      chk("cfg_w_640", cfg_width, 640);
      chk("cfg_h_480", cfg_height, 480);
      chk("start_kept", ap_start, 1);
      axi_write(6'h00, 32'h01, 4'hF, 0, 0, 0);
      pulse_ready();
      chk("start_cleared", ap_start, 0);
      axi_write(6'h00, 32'h00, 4'hF, 0, 0, 0);
      check_state("w0_noclr");

      // skewed channels, stalled bready, byte strobes
      axi_write(6'h20, 32'h1234, 4'hF, 0, 3, 4);
      axi_write(6'h18, 32'h0000_0300, 4'hF, 3, 0, 4);
      axi_write(6'h10, 32'hFFFF_FFFF, 4'b0001, 1, 1, 0);
      axi_read(6'h10, 0, 0, rd);
      chk("wstrb_width", rd, 32'h2FF);
      axi_write(6'h10, 32'hFFFF_FFFF, 4'b0000, 0, 0, 1);
      axi_read(6'h10, 0, 0, rd);
      chk("strb0_noop", rd, 32'h2FF);
      check_state("noshadow");

      // sticky done, clear-on-read, coincident event
      pulse_done();
      axi_read(6'h00, 0, 0, rd);
      chk("done_set", rd[1], 1);
      axi_read(6'h00, 0, 0, rd);
      chk("done_cleared", rd[1], 0);
      axi_read(6'h00, 0, 1, rd);
      chk("done_prior", rd[1], 0);
      axi_read(6'h00, 0, 0, rd);
      chk("done_event_wins", rd[1], 1);

      // unmapped offset, stalled rready
      axi_write(6'h3C, 32'hDEAD_BEEF, 4'hF, 0, 0, 2);
      axi_read(6'h3C, 5, 0, rd);
      axi_read(6'h10, 0, 0, rd);
      axi_read(6'h18, 0, 0, rd);
      axi_read(6'h20, 0, 0, rd);
      axi_read(6'h28, 0, 0, rd);
      axi_read(6'h30, 0, 0, rd);

`ifdef VFB_IRQ_EN
      axi_write(6'h0C, 32'(m_isr), 4'hF, 0, 0, 0);
      axi_write(6'h04, 1, 4'hF, 0, 0, 0);
      axi_write(6'h08, 1, 4'hF, 0, 0, 0);
      chk("irq_idle", irq, 0);
      pulse_done();
      chk("irq_lat0", irq, 0);
      @(posedge clk); #1;
      chk("irq_set", irq, 1);
      axi_write(6'h0C, 1, 4'hF, 0, 0, 0);
      chk("irq_cleared", irq, 0);
`else
      chk("irq_const0", irq, 0);
      axi_read(6'h04, 0, 0, rd);
      chk("gie_slverr", s_rresp, 2'b10);
`endif

      // randomized traffic against the model
      for (int it = 0; it < 60; it++) begin
         op = int'($urandom_range(0, 9));
         a = offs[$urandom_range(0, 11)] | 6'($urandom_range(0, 3));
         if (op <= 3)
            axi_write(a, $urandom, 4'($urandom),
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
         else if (op <= 6)
            axi_read(a, int'($urandom_range(0, 3)), 0, rd);
         else if (op == 7)
            pulse_ready();
         else if (op == 8)
            pulse_done();
         else
            ap_idle = 1'($urandom);
         check_state("rand");
      end

      // reset with a captured AW pending: no response, no stale address
      s_awaddr = 6'h10; s_awvalid = 1;
      @(posedge clk); #1;
      s_awvalid = 0;
      reset = 1;
      @(negedge clk);
      chk("midrst_bvalid", s_bvalid, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 0;
      m_reset();
      @(negedge clk);
      chk("postrst_bvalid", s_bvalid, 0);
      @(posedge clk); #1;
      axi_write(6'h18, 7, 4'hF, 0, 1, 0);
      axi_read(6'h18, 0, 0, rd);
      chk("postrst_height", rd, 7);
      axi_read(6'h10, 0, 0, rd);
      check_state("postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
